imem_loader: RTL

//  Writer side of the instruction memory: receives a program as a byte stream over a valid/ready

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream LSB-first into 32-bit words; flags the byte that completes a word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [INSTR_W-9:0] asm_q, asm_d;

  // The final byte is used directly, so only the lower three lanes need storage.
  assign word_valid_o = byte_valid_i && !clear_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
  assign word_o       = {byte_i, asm_q};

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      case (lane_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: asm_d        = asm_q;
      endcase
      lane_d = lane_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header check, word packing and instruction-memory write port.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  state_e             state_q, state_d;
  logic [7:0]         n_q, n_d;
  logic [ADDR_W:0]    word_idx_q, word_idx_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               xfer;
  logic               word_valid;
  logic [INSTR_W-1:0] word;

  assign in_ready = (state_q == StHdr) || (state_q == StData);
  assign xfer     = in_valid && in_ready;

  imem_byte_packer u_packer (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (state_q == StHdr),
    .byte_valid_i (xfer && (state_q == StData)),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StHdr;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      StHdr: begin
        if (xfer) begin
          if ((in_data == 8'd0) || (in_data > 8'(DEPTH))) begin
            state_d = StError;
            error_d = 1'b1;
          end else begin
            state_d    = StData;
            n_d        = in_data;
            word_idx_d = '0;
          end
        end
      end
      StData: begin
        if (word_valid) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = word_idx_q[ADDR_W-1:0];
          wr_data_d  = word;
          word_idx_d = word_idx_q + 1'b1;
          // Done and cpu release land on the same edge as the final write strobe.
          if ((8'(word_idx_q) + 8'd1) == n_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_idx_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
